overlay_frame_ctrl: RTL and testbench

- Frame-synchronous scheduler for the detection-box overlay drawn by the video overlay stage.
- Three detection engines post box updates over valid/ready; a round-robin arbiter accepts one per cycle into shadow registers.
- Shadow registers commit to the overlay coordinate outputs only at VSync rising edge, so the overlay never tears mid-frame.
- Also ages stale boxes and keeps a 4-digit BCD count of accepted detections for the on-screen digit display.

---
 rtl/overlay_frame_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_overlay_frame_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/overlay_frame_ctrl.sv
// Frame-synchronous detection-box overlay scheduler: round-robin update intake,
// VSync-aligned commit, stale-box ageing and BCD detection count. Option: OVERLAY_CLAMP_EN.
module overlay_frame_ctrl #(
  parameter logic [10:0] X_MAX       = 11'd1279,
  parameter logic [9:0]  Y_MAX       = 10'd719,
  parameter logic [7:0]  HOLD_FRAMES = 8'd30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync,
  input  logic [2:0]  req_valid,
  output logic [2:0]  req_ready,
  input  logic [32:0] req_left,
  input  logic [32:0] req_right,
  input  logic [29:0] req_top,
  input  logic [29:0] req_bottom,
  output logic [10:0] left1,
  output logic [10:0] right1,
  output logic [9:0]  top1,
  output logic [9:0]  bottom1,
  output logic [10:0] left2,
  output logic [10:0] right2,
  output logic [9:0]  top2,
  output logic [9:0]  bottom2,
  output logic [10:0] left3,
  output logic [10:0] right3,
  output logic [9:0]  top3,
  output logic [9:0]  bottom3,
  output logic [2:0]  box_vis,
  output logic [3:0]  num1,
  output logic [3:0]  num2,
  output logic [3:0]  num3,
  output logic [3:0]  num4,
  output logic        coord_err
);

  localparam logic [10:0] HID_X = 11'h7FF;
  localparam logic [9:0]  HID_Y = 10'h3FF;

  typedef enum logic [1:0] {S_RUN, S_COMMIT, S_AGE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_vsync_d;
  logic        w_vs_rise;
  logic [1:0]  r_rr_ptr;
  logic        r_err;
  logic [3:0]  r_cnt [4];
  logic [3:0]  r_num [4];
  logic [3:0]  w_cnt_inc [4];
  logic        w_carry;

  logic        w_gnt_found;
  logic [1:0]  w_gnt_idx;
  logic [1:0]  w_ptr_next;
  logic [2:0]  w_sum;
  logic [1:0]  w_cand;
  logic [10:0] w_sel_l, w_sel_r, w_r_eff;
  logic [9:0]  w_sel_t, w_sel_b, w_b_eff;
  logic        w_legal;

  logic [10:0] w_o_l [3];
  logic [10:0] w_o_r [3];
  logic [9:0]  w_o_t [3];
  logic [9:0]  w_o_b [3];
  logic [2:0]  w_vis;

  assign w_vs_rise = vsync & ~r_vsync_d;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RUN:    if (w_vs_rise) w_state_next = S_COMMIT;
      S_COMMIT: w_state_next = S_AGE;
      S_AGE:    w_state_next = S_RUN;
      default:  w_state_next = S_RUN;
    endcase
  end

  // Round-robin search starting at the pointer; a VSync edge suppresses all grants.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = 2'd0;
    w_sum       = 3'd0;
    w_cand      = 2'd0;
    if (rst_n && (r_state == S_RUN) && !w_vs_rise) begin
      for (int k = 0; k < 3; k++) begin
        w_sum  = {1'b0, r_rr_ptr} + 3'(k);
        w_cand = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];
        if (!w_gnt_found && req_valid[w_cand]) begin
          w_gnt_found = 1'b1;
          w_gnt_idx   = w_cand;
        end
      end
    end
  end

  assign req_ready  = w_gnt_found ? (3'b001 << w_gnt_idx) : 3'b000;
  assign w_ptr_next = (w_gnt_idx == 2'd2) ? 2'd0 : w_gnt_idx + 2'd1;

  always_comb begin
    case (w_gnt_idx)
      2'd1: begin
        w_sel_l = req_left[21:11];  w_sel_r = req_right[21:11];
        w_sel_t = req_top[19:10];   w_sel_b = req_bottom[19:10];
      end
      2'd2: begin
        w_sel_l = req_left[32:22];  w_sel_r = req_right[32:22];
        w_sel_t = req_top[29:20];   w_sel_b = req_bottom[29:20];
      end
      default: begin
        w_sel_l = req_left[10:0];   w_sel_r = req_right[10:0];
        w_sel_t = req_top[9:0];     w_sel_b = req_bottom[9:0];
      end
    endcase
  end

`ifdef OVERLAY_CLAMP_EN
  assign w_r_eff = (w_sel_r > X_MAX) ? X_MAX : w_sel_r;
  assign w_b_eff = (w_sel_b > Y_MAX) ? Y_MAX : w_sel_b;
`else
  assign w_r_eff = w_sel_r;
  assign w_b_eff = w_sel_b;
`endif

  assign w_legal = (w_sel_l <= w_r_eff) && (w_sel_t <= w_b_eff) &&
                   (w_r_eff <= X_MAX) && (w_b_eff <= Y_MAX);

  // Ripple-carry BCD increment; 9999 rolls over to 0000.
  always_comb begin
    w_carry = 1'b1;
    for (int d = 0; d < 4; d++) begin
      w_cnt_inc[d] = r_cnt[d];
      if (w_carry) begin
        if (r_cnt[d] == 4'd9) begin
          w_cnt_inc[d] = 4'd0;
        end else begin
          w_cnt_inc[d] = r_cnt[d] + 4'd1;
          w_carry      = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_RUN;
      r_vsync_d <= 1'b0;
      r_rr_ptr  <= 2'd0;
      r_err     <= 1'b0;
      for (int d = 0; d < 4; d++) begin
        r_cnt[d] <= 4'd0;
        r_num[d] <= 4'd0;
      end
    end else begin
      r_state   <= w_state_next;
      r_vsync_d <= vsync;
      if (w_gnt_found) begin
        r_rr_ptr <= w_ptr_next;
        if (w_legal) r_cnt <= w_cnt_inc;
        else         r_err <= 1'b1;
      end
      if (r_state == S_COMMIT) r_num <= r_cnt;
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : gen_box
      logic [10:0] r_sh_l, r_sh_r, r_o_l, r_o_r;
      logic [9:0]  r_sh_t, r_sh_b, r_o_t, r_o_b;
      logic        r_pend, r_vis, r_refr;
      logic [7:0]  r_age;
      logic        w_wr;

      assign w_wr = w_gnt_found && w_legal && (w_gnt_idx == 2'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sh_l <= HID_X; r_sh_r <= HID_X; r_sh_t <= HID_Y; r_sh_b <= HID_Y;
          r_o_l  <= HID_X; r_o_r  <= HID_X; r_o_t  <= HID_Y; r_o_b  <= HID_Y;
          r_pend <= 1'b0;
          r_vis  <= 1'b0;
          r_refr <= 1'b0;
          r_age  <= 8'd0;
        end else begin
          if (w_wr) begin
            r_sh_l <= w_sel_l; r_sh_r <= w_r_eff;
            r_sh_t <= w_sel_t; r_sh_b <= w_b_eff;
            r_pend <= 1'b1;
          end
          if (r_state == S_COMMIT) begin
            r_refr <= r_pend;
            if (r_pend) begin
              r_o_l <= r_sh_l; r_o_r <= r_sh_r; r_o_t <= r_sh_t; r_o_b <= r_sh_b;
              r_vis  <= 1'b1;
              r_age  <= 8'd0;
              r_pend <= 1'b0;
            end
          end else if ((r_state == S_AGE) && r_vis && !r_refr) begin
            // Hidden boxes are not aged, so age never runs past HOLD_FRAMES.
            if (r_age + 8'd1 == HOLD_FRAMES) begin
              r_o_l <= HID_X; r_o_r <= HID_X; r_o_t <= HID_Y; r_o_b <= HID_Y;
              r_vis <= 1'b0;
              r_age <= 8'd0;
            end else begin
              r_age <= r_age + 8'd1;
            end
          end
        end
      end

      assign w_o_l[gi] = r_o_l;
      assign w_o_r[gi] = r_o_r;
      assign w_o_t[gi] = r_o_t;
      assign w_o_b[gi] = r_o_b;
      assign w_vis[gi] = r_vis;
    end
  endgenerate

  assign left1 = w_o_l[0]; assign right1 = w_o_r[0]; assign top1 = w_o_t[0]; assign bottom1 = w_o_b[0];
  assign left2 = w_o_l[1]; assign right2 = w_o_r[1]; assign top2 = w_o_t[1]; assign bottom2 = w_o_b[1];
  assign left3 = w_o_l[2]; assign right3 = w_o_r[2]; assign top3 = w_o_t[2]; assign bottom3 = w_o_b[2];
  assign box_vis   = w_vis;
  assign num1      = r_num[0];
  assign num2      = r_num[1];
  assign num3      = r_num[2];
  assign num4      = r_num[3];
  assign coord_err = r_err;

endmodule

// File: tb/tb_overlay_frame_ctrl.sv
// Randomized/directed bench for overlay_frame_ctrl against a frame-level reference model.
module tb_overlay_frame_ctrl;
  localparam int XM = 1279, YM = 719, HOLD = 30;

  logic        clk = 1'b0, rst_n = 1'b0, vsync = 1'b0;
  logic [2:0]  req_valid = 3'b0;
  logic [2:0]  req_ready;
  logic [32:0] req_left = '0, req_right = '0;
  logic [29:0] req_top = '0, req_bottom = '0;
  logic [10:0] left1, right1, left2, right2, left3, right3;
  logic [9:0]  top1, bottom1, top2, bottom2, top3, bottom3;
  logic [2:0]  box_vis;
  logic [3:0]  num1, num2, num3, num4;
  logic        coord_err;

  overlay_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_left(req_left), .req_right(req_right), .req_top(req_top), .req_bottom(req_bottom),
    .left1(left1), .right1(right1), .top1(top1), .bottom1(bottom1),
    .left2(left2), .right2(right2), .top2(top2), .bottom2(bottom2),
    .left3(left3), .right3(right3), .top3(top3), .bottom3(bottom3),
    .box_vis(box_vis), .num1(num1), .num2(num2), .num3(num3), .num4(num4),
    .coord_err(coord_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // requester side
  bit [2:0] rq_v;
  int rq_l[3], rq_r[3], rq_t[3], rq_b[3];
  logic [2:0] last_ready;

  // reference model
  int  m_phase;       // 0 = running, 1 = commit cycle, 2 = age cycle
  bit  m_vs_prev;
  int  m_ptr;
  int  sh_l[3], sh_r[3], sh_t[3], sh_b[3];
  bit  pend[3], refr[3], vis[3];
  int  o_l[3], o_r[3], o_t[3], o_b[3], age[3];
  int  m_count, m_shown;
  bit  m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [41:0] dut_box(input int i);
    case (i)
      0:       return {left1, right1, top1, bottom1};
      1:       return {left2, right2, top2, bottom2};
      default: return {left3, right3, top3, bottom3};
    endcase
  endfunction

  function automatic logic [15:0] bcd(input int c);
    return {4'((c / 1000) % 10), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  task automatic hide_box(input int i);
    o_l[i] = 2047; o_r[i] = 2047; o_t[i] = 1023; o_b[i] = 1023;
  endtask

  task automatic model_reset();
    m_phase = 0; m_vs_prev = 0; m_ptr = 0; m_count = 0; m_shown = 0; m_err = 0;
    for (int i = 0; i < 3; i++) begin
      hide_box(i);
      sh_l[i] = 2047; sh_r[i] = 2047; sh_t[i] = 1023; sh_b[i] = 1023;
      pend[i] = 0; refr[i] = 0; vis[i] = 0; age[i] = 0;
    end
  endtask

  task automatic apply_bus();
    for (int i = 0; i < 3; i++) begin
      req_valid[i]          = rq_v[i];
      req_left[i*11 +: 11]  = 11'(rq_l[i]);
      req_right[i*11 +: 11] = 11'(rq_r[i]);
      req_top[i*10 +: 10]   = 10'(rq_t[i]);
      req_bottom[i*10 +: 10] = 10'(rq_b[i]);
    end
  endtask

  function automatic int pred_grant();
    if (m_phase != 0 || (vsync && !m_vs_prev)) return -1;
    for (int k = 0; k < 3; k++)
      if (rq_v[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
    return -1;
  endfunction

  task automatic model_accept(input int i);
    int r, b;
    r = rq_r[i]; b = rq_b[i];
`ifdef OVERLAY_CLAMP_EN
    if (r > XM) r = XM;
    if (b > YM) b = YM;
`endif
    if (rq_l[i] <= r && rq_t[i] <= b && r <= XM && b <= YM) begin
      sh_l[i] = rq_l[i]; sh_r[i] = r; sh_t[i] = rq_t[i]; sh_b[i] = b;
      pend[i] = 1;
      m_count = (m_count + 1) % 10000;
    end else begin
      m_err = 1;
    end
  endtask

  task automatic model_edge(input int g);
    bit rise;
    rise = vsync && !m_vs_prev;
    if (m_phase == 1) begin
      for (int i = 0; i < 3; i++) begin
        refr[i] = pend[i];
        if (pend[i]) begin
          o_l[i] = sh_l[i]; o_r[i] = sh_r[i]; o_t[i] = sh_t[i]; o_b[i] = sh_b[i];
          vis[i] = 1; age[i] = 0; pend[i] = 0;
        end
      end
      m_shown = m_count;
      m_phase = 2;
    end else if (m_phase == 2) begin
      for (int i = 0; i < 3; i++) begin
        if (vis[i] && !refr[i]) begin
          age[i]++;
          if (age[i] == HOLD) begin
            hide_box(i); vis[i] = 0; age[i] = 0;
          end
        end
      end
      m_phase = 0;
    end else if (rise) begin
      m_phase = 1;
    end else if (g >= 0) begin
      model_accept(g);
      m_ptr = (g + 1) % 3;
      rq_v[g] = 0;
    end
    m_vs_prev = vsync;
  endtask

  task automatic check_outputs();
    chk("box1", dut_box(0), {11'(o_l[0]), 11'(o_r[0]), 10'(o_t[0]), 10'(o_b[0])});
    chk("box2", dut_box(1), {11'(o_l[1]), 11'(o_r[1]), 10'(o_t[1]), 10'(o_b[1])});
    chk("box3", dut_box(2), {11'(o_l[2]), 11'(o_r[2]), 10'(o_t[2]), 10'(o_b[2])});
    chk("box_vis", box_vis, {vis[2], vis[1], vis[0]});
    chk("num", {num4, num3, num2, num1}, bcd(m_shown));
    chk("coord_err", coord_err, m_err);
  endtask

  // One clock: inputs applied just after an edge, ready checked mid-cycle, outputs after the edge.
  task automatic tick();
    int g;
    apply_bus();
    @(negedge clk);
    g = pred_grant();
    last_ready = req_ready;
    chk("req_ready", req_ready, (g < 0) ? 3'b000 : (3'b001 << g));
    @(posedge clk);
    #1;
    model_edge(g);
    check_outputs();
  endtask

  task automatic set_legal(input int i);
    rq_l[i] = $urandom_range(0, XM);  rq_r[i] = $urandom_range(rq_l[i], XM);
    rq_t[i] = $urandom_range(0, YM);  rq_b[i] = $urandom_range(rq_t[i], YM);
    rq_v[i] = 1;
  endtask

  task automatic set_random(input int i);
    if ($urandom_range(0, 3) != 0) begin
      set_legal(i);
    end else begin
      rq_l[i] = $urandom_range(0, 2047); rq_r[i] = $urandom_range(0, 2047);
      rq_t[i] = $urandom_range(0, 1023); rq_b[i] = $urandom_range(0, 1023);
      rq_v[i] = 1;
    end
  endtask

  task automatic wait_grant(input int i);
    for (int n = 0; n < 20 && rq_v[i]; n++) tick();
    chk("grant_wait", rq_v[i], 1'b0);
  endtask

  // early: requests raised with the VSync edge; late: requests raised once back in RUN.
  task automatic frame(input int len, input int vs_hi, input bit [2:0] early,
                       input bit [2:0] late, input bit rnd);
    for (int n = 0; n < len; n++) begin
      vsync = (n < vs_hi);
      for (int i = 0; i < 3; i++) begin
        if (!rq_v[i] && ((n == 0 && early[i]) || (n == 4 && late[i]))) set_legal(i);
        if (rnd && !rq_v[i] && $urandom_range(0, 3) == 0) set_random(i);
      end
      tick();
    end
    vsync = 0;
  endtask

  initial begin
    rq_v = 0;
    for (int i = 0; i < 3; i++) begin rq_l[i] = 0; rq_r[i] = 0; rq_t[i] = 0; rq_b[i] = 0; end
    model_reset();
    apply_bus();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    chk("rst_ready", req_ready, 3'b000);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;

    // Idle frames: nothing changes.
    repeat (3) frame(12, 3, 3'b000, 3'b000, 0);
    chk("idle_vis", box_vis, 3'b000);
    chk("idle_num", {num4, num3, num2, num1}, 16'h0000);

    // All three valid: grants 0,1,2 in order, committed at next frame.
    for (int i = 0; i < 3; i++) set_legal(i);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("grant_seq", last_ready, 3'b001 << k);
    end
    frame(12, 3, 3'b000, 3'b000, 0);
    chk("all_vis", box_vis, 3'b111);
    chk("num_3", {num4, num3, num2, num1}, 16'h0003);

    // Valid raised with the VSync edge: grant deferred until RUN.
    frame(12, 3, 3'b001, 3'b000, 0);
    frame(12, 3, 3'b000, 3'b000, 0);

    // Illegal order: still handshaken, flagged, nothing committed.
    rq_l[0] = 500; rq_r[0] = 400; rq_t[0] = 10; rq_b[0] = 20; rq_v[0] = 1;
    wait_grant(0);
    chk("err_set", coord_err, 1'b1);
    frame(12, 3, 3'b000, 3'b000, 0);
`ifdef OVERLAY_CLAMP_EN
    rq_l[1] = 100; rq_r[1] = 1400; rq_t[1] = 5; rq_b[1] = 6; rq_v[1] = 1;
    wait_grant(1);
    frame(12, 3, 3'b000, 3'b000, 0);
    chk("clamp_right", right2, 11'd1279);
`endif

    // Ageing: box 2 left alone while boxes 1 and 3 are refreshed each frame.
    set_legal(1);
    wait_grant(1);
    frame(12, 3, 3'b000, 3'b000, 0);
    repeat (HOLD - 1) frame(12, 3, 3'b000, 3'b101, 0);
    chk("age_hold", box_vis[1], 1'b1);
    frame(12, 3, 3'b000, 3'b101, 0);
    chk("age_hidden", box_vis, 3'b101);

    // Random traffic, including illegal updates and varied frame timing.
    repeat (30) frame($urandom_range(10, 40), $urandom_range(1, 6), 3'b000, 3'b000, 1);
    for (int n = 0; n < 10 && rq_v != 0; n++) tick();

    // Counter wrap: bring the count to 9999, then one more.
    for (int n = 0; n < 12000 && m_count != 9999; n++) begin
      if (rq_v == 0) set_legal($urandom_range(0, 2));
      tick();
    end
    frame(12, 3, 3'b000, 3'b000, 0);
    chk("num_9999", {num4, num3, num2, num1}, 16'h9999);
    set_legal(2);
    wait_grant(2);
    frame(12, 3, 3'b000, 3'b000, 0);
    chk("num_wrap", {num4, num3, num2, num1}, 16'h0000);

    // Reset mid-frame with requests outstanding.
    set_legal(0); set_legal(1);
    tick();
    #2 rst_n = 0;
    #1;
    model_reset();
    check_outputs();
    chk("rst_ready_mid", req_ready, 3'b000);
    rq_v = 0; vsync = 0;
    apply_bus();
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    check_outputs();
    frame(12, 3, 3'b000, 3'b000, 0);
    chk("rst_lost", box_vis, 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
